m92_sound_comm: RTL and testbench
=================================

M92_SOUND_COMM -- requirements
Module: m92_sound_comm

Interface
REQ-001 SHALL have port clk_sys, input, 1 bit: sole clock (40 MHz system clock).
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port main_cmd_wr, input, 1 bit: main-CPU write strobe for the command register.
REQ-004 SHALL have port main_cmd_din, input, 8 bits: command byte from the main CPU.
REQ-005 SHALL have port main_reply_rd, input, 1 bit: main-CPU read strobe for the reply register.
REQ-006 SHALL have port main_reply_dout, output, 8 bits: reply byte to the main CPU.
REQ-007 SHALL have port main_irq, output, 1 bit: reply-pending interrupt to the main CPU.
REQ-008 SHALL have port snd_cmd_dout, output, 8 bits: command byte presented to the V35 at 0xa8044.
REQ-009 SHALL have port snd_cmd_ack, input, 1 bit: V35 write strobe to 0xa8044, acknowledging or popping the command.
REQ-010 SHALL have port snd_irq, output, 1 bit: command-pending interrupt to the V35.
REQ-011 SHALL have port snd_reply_wr, input, 1 bit: V35 write strobe to 0xa8046.
REQ-012 SHALL have port snd_reply_din, input, 8 bits: reply byte from the V35.
REQ-013 SHALL have port cmd_overrun, output, 1 bit: sticky flag for a lost or overwritten command.

Function
REQ-014 SHALL treat each strobe (main_cmd_wr, main_reply_rd, snd_cmd_ack, snd_reply_wr) as one event per low-to-high transition, using an internal registered copy of each strobe; a strobe held high for several cycles SHALL count once.
REQ-015 SHALL update state on the first clk_sys edge at which a strobe is sampled high after being sampled low; outputs SHALL reflect the update immediately after that edge (one-cycle latency).
REQ-016 Command path without FIFO: a write event SHALL store main_cmd_din and set cmd_pending; snd_cmd_dout SHALL equal the stored byte; snd_irq SHALL equal cmd_pending.
REQ-017 Command path without FIFO: an ack event SHALL clear cmd_pending and retain the data.
REQ-018 A write event while cmd_pending=1 and no ack in the same cycle SHALL overwrite the data and set cmd_overrun.
REQ-019 A write event and an ack event in the same cycle SHALL leave cmd_pending=1 holding the new byte, without setting overrun.
REQ-020 An ack event while nothing is pending SHALL have no effect.
REQ-021 Reply path: an snd_reply_wr event SHALL store snd_reply_din and set reply_pending; main_irq SHALL equal reply_pending; a main_reply_rd event SHALL clear reply_pending and retain the data.
REQ-022 Reply path: a reply write and a reply read in the same cycle SHALL leave reply_pending=1 with the new data.
REQ-023 A reply write while reply_pending=1 SHALL overwrite the data and SHALL NOT affect cmd_overrun.
REQ-024 cmd_overrun SHALL be sticky and cleared only by reset.

Reset
REQ-025 Reset SHALL asynchronously force: command data 0xFF, reply data 0xFF, all pending flags 0, snd_irq 0, main_irq 0, cmd_overrun 0, FIFO pointers and count 0, and all strobe history registers 0.
REQ-026 A strobe held high across reset deassertion SHALL NOT produce an event until it goes low and high again.

Configuration
REQ-027 With macro SOUND_CMD_FIFO_EN defined, the command path SHALL be a 4-entry FIFO with 2-bit wrapping pointers and a 3-bit count.
REQ-028 With SOUND_CMD_FIFO_EN, a write event SHALL push; snd_cmd_dout SHALL show the head entry (0xFF when empty); an ack event SHALL pop; snd_irq SHALL be 1 whenever count is not 0.
REQ-029 With SOUND_CMD_FIFO_EN, a push when count=4 with no pop SHALL be dropped and set cmd_overrun; a push and pop in the same cycle SHALL both occur at any count, including full; a pop when empty SHALL be ignored.
REQ-030 Without SOUND_CMD_FIFO_EN, the single-latch behaviour of REQ-016 to REQ-020 SHALL apply; the reply path SHALL be identical in both builds.

Verification
REQ-031 Reset, then write main_cmd_wr with 0x5A -> one cycle later snd_cmd_dout=0x5A and snd_irq=1; ack -> snd_irq=0 and snd_cmd_dout stays 0x5A.
REQ-032 Hold main_cmd_wr high for 5 cycles with data 0x11 -> exactly one event; in the FIFO build count=1.
REQ-033 No-FIFO build: write 0x01, then write 0x02 with no ack -> snd_cmd_dout=0x02 and cmd_overrun=1; after reset cmd_overrun=0.
REQ-034 FIFO build: push 0x10, 0x20, 0x30, 0x40, 0x50 -> 0x50 dropped and overrun=1; four acks yield 0x10, 0x20, 0x30, 0x40, then snd_irq=0 and dout=0xFF.
REQ-035 Reply 0xA5 via snd_reply_wr with main_reply_rd in the same cycle -> main_irq=1 and main_reply_dout=0xA5; a later read -> main_irq=0.
REQ-036 Assert reset mid-sequence with pending command and reply -> all outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/m92_sound_comm.sv
// M92 main<->V35 sound latch pair; cmd path is a 4-deep FIFO when SOUND_CMD_FIFO_EN is defined.
// Latency: one clk_sys after a strobe rising edge. No backpressure: overflow sets sticky cmd_overrun.
module m92_sound_comm (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       main_cmd_wr,
  input  logic [7:0] main_cmd_din,
  input  logic       main_reply_rd,
  output logic [7:0] main_reply_dout,
  output logic       main_irq,
  output logic [7:0] snd_cmd_dout,
  input  logic       snd_cmd_ack,
  output logic       snd_irq,
  input  logic       snd_reply_wr,
  input  logic [7:0] snd_reply_din,
  output logic       cmd_overrun
);

  logic cmd_wr_q, reply_rd_q, cmd_ack_q, reply_wr_q, armed_q;
  logic wr_ev, rd_ev, ack_ev, rw_ev;

  // armed_q blocks events on the first edge after reset, so a strobe held through reset needs a fresh low
  assign wr_ev  = armed_q & main_cmd_wr   & ~cmd_wr_q;
  assign rd_ev  = armed_q & main_reply_rd & ~reply_rd_q;
  assign ack_ev = armed_q & snd_cmd_ack   & ~cmd_ack_q;
  assign rw_ev  = armed_q & snd_reply_wr  & ~reply_wr_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cmd_wr_q   <= 1'b0;
      reply_rd_q <= 1'b0;
      cmd_ack_q  <= 1'b0;
      reply_wr_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      cmd_wr_q   <= main_cmd_wr;
      reply_rd_q <= main_reply_rd;
      cmd_ack_q  <= snd_cmd_ack;
      reply_wr_q <= snd_reply_wr;
      armed_q    <= 1'b1;
    end
  end

  logic [7:0] reply_dat_q, reply_dat_d;
  logic       reply_pend_q, reply_pend_d;
  logic       ovr_q, ovr_d;

  always_comb begin
    reply_dat_d  = reply_dat_q;
    reply_pend_d = reply_pend_q;
    if (rw_ev) begin
      reply_dat_d  = snd_reply_din;
      reply_pend_d = 1'b1;
    end else if (rd_ev) begin
      reply_pend_d = 1'b0;
    end
  end

`ifdef SOUND_CMD_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       push, pop, full;

  // pop first so a push against a full FIFO succeeds when the V35 acks in the same cycle
  assign pop  = ack_ev & (cnt_q != 3'd0);
  assign full = (cnt_q == 3'd4);
  assign push = wr_ev & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    cnt_d    = cnt_q + 3'(push) - 3'(pop);
    ovr_d    = ovr_q | (wr_ev & full & ~pop);
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr_q] <= main_cmd_din;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign snd_cmd_dout = (cnt_q != 3'd0) ? mem[rd_ptr_q] : 8'hFF;
  assign snd_irq      = (cnt_q != 3'd0);
`else
  logic [7:0] cmd_dat_q, cmd_dat_d;
  logic       cmd_pend_q, cmd_pend_d;

  always_comb begin
    cmd_dat_d  = cmd_dat_q;
    cmd_pend_d = cmd_pend_q;
    ovr_d      = ovr_q;
    if (wr_ev) begin
      cmd_dat_d  = main_cmd_din;
      cmd_pend_d = 1'b1;
      if (cmd_pend_q && !ack_ev) ovr_d = 1'b1;
    end else if (ack_ev) begin
      cmd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cmd_dat_q  <= 8'hFF;
      cmd_pend_q <= 1'b0;
    end else begin
      cmd_dat_q  <= cmd_dat_d;
      cmd_pend_q <= cmd_pend_d;
    end
  end

  assign snd_cmd_dout = cmd_dat_q;
  assign snd_irq      = cmd_pend_q;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      reply_dat_q  <= 8'hFF;
      reply_pend_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      reply_dat_q  <= reply_dat_d;
      reply_pend_q <= reply_pend_d;
      ovr_q        <= ovr_d;
    end
  end

  assign main_reply_dout = reply_dat_q;
  assign main_irq        = reply_pend_q;
  assign cmd_overrun     = ovr_q;

endmodule

// File: tb/tb_m92_sound_comm.sv
// Scoreboard bench for m92_sound_comm; reference model pushes expected outputs per operation.
module tb_m92_sound_comm;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       main_cmd_wr = 1'b0, main_reply_rd = 1'b0, snd_cmd_ack = 1'b0, snd_reply_wr = 1'b0;
  logic [7:0] main_cmd_din = 8'h00, snd_reply_din = 8'h00;
  logic [7:0] main_reply_dout, snd_cmd_dout;
  logic       main_irq, snd_irq, cmd_overrun;

  m92_sound_comm dut (
    .clk_sys(clk_sys), .reset(reset),
    .main_cmd_wr(main_cmd_wr), .main_cmd_din(main_cmd_din),
    .main_reply_rd(main_reply_rd), .main_reply_dout(main_reply_dout), .main_irq(main_irq),
    .snd_cmd_dout(snd_cmd_dout), .snd_cmd_ack(snd_cmd_ack), .snd_irq(snd_irq),
    .snd_reply_wr(snd_reply_wr), .snd_reply_din(snd_reply_din), .cmd_overrun(cmd_overrun)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0] cd;
    logic       si;
    logic [7:0] rd;
    logic       mi;
    logic       ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] m_cmd_dat, m_rep_dat;
  logic       m_cmd_pend, m_rep_pend, m_ovr;
  logic [7:0] m_fifo[$];

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cmd_dat = 8'hFF; m_cmd_pend = 1'b0; m_rep_dat = 8'hFF; m_rep_pend = 1'b0; m_ovr = 1'b0;
    m_fifo.delete();
  endtask

  task automatic model_apply(input logic cw, input logic [7:0] cd, input logic ca,
                             input logic rw, input logic [7:0] rdin, input logic rr);
    logic [7:0] tmp;
`ifdef SOUND_CMD_FIFO_EN
    if (ca && m_fifo.size() != 0) tmp = m_fifo.pop_front();
    if (cw) begin
      if (m_fifo.size() < 4) m_fifo.push_back(cd);
      else m_ovr = 1'b1;
    end
`else
    tmp = cd;
    if (cw && ca) begin
      m_cmd_dat = tmp; m_cmd_pend = 1'b1;
    end else if (cw) begin
      if (m_cmd_pend) m_ovr = 1'b1;
      m_cmd_dat = tmp; m_cmd_pend = 1'b1;
    end else if (ca) begin
      m_cmd_pend = 1'b0;
    end
`endif
    if (rw) begin
      m_rep_dat = rdin; m_rep_pend = 1'b1;
    end else if (rr) begin
      m_rep_pend = 1'b0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
`ifdef SOUND_CMD_FIFO_EN
    e.cd = (m_fifo.size() != 0) ? m_fifo[0] : 8'hFF;
    e.si = (m_fifo.size() != 0);
`else
    e.cd = m_cmd_dat;
    e.si = m_cmd_pend;
`endif
    e.rd = m_rep_dat;
    e.mi = m_rep_pend;
    e.ov = m_ovr;
    sb_q.push_back(e);
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    check_val({tag, ".snd_cmd_dout"}, snd_cmd_dout, e.cd);
    check_val({tag, ".snd_irq"}, {7'd0, snd_irq}, {7'd0, e.si});
    check_val({tag, ".main_reply_dout"}, main_reply_dout, e.rd);
    check_val({tag, ".main_irq"}, {7'd0, main_irq}, {7'd0, e.mi});
    check_val({tag, ".cmd_overrun"}, {7'd0, cmd_overrun}, {7'd0, e.ov});
  endtask

  task automatic op(input string tag, input logic cw, input logic [7:0] cd, input logic ca,
                    input logic rw, input logic [7:0] rdin, input logic rr);
    @(negedge clk_sys);
    main_cmd_wr = cw; main_cmd_din = cd; snd_cmd_ack = ca;
    snd_reply_wr = rw; snd_reply_din = rdin; main_reply_rd = rr;
    @(negedge clk_sys);
    main_cmd_wr = 1'b0; snd_cmd_ack = 1'b0; snd_reply_wr = 1'b0; main_reply_rd = 1'b0;
    model_apply(cw, cd, ca, rw, rdin, rr);
    push_exp();
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_sys);
    reset = 1'b1;
    main_cmd_wr = 1'b0; snd_cmd_ack = 1'b0; snd_reply_wr = 1'b0; main_reply_rd = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    push_exp();
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    push_exp();
    check_outputs("reset");

    op("wr5a", 1, 8'h5A, 0, 0, 8'h00, 0);
    op("ack5a", 0, 8'h00, 1, 0, 8'h00, 0);
    op("ack_empty", 0, 8'h00, 1, 0, 8'h00, 0);

    // held write strobe must register as a single event
    @(negedge clk_sys);
    main_cmd_wr = 1'b1; main_cmd_din = 8'h11;
    repeat (5) @(negedge clk_sys);
    main_cmd_wr = 1'b0;
    model_apply(1, 8'h11, 0, 0, 8'h00, 0);
    push_exp();
    check_outputs("hold11");
    op("hold11_ack", 0, 8'h00, 1, 0, 8'h00, 0);

`ifdef SOUND_CMD_FIFO_EN
    op("push10", 1, 8'h10, 0, 0, 8'h00, 0);
    op("push20", 1, 8'h20, 0, 0, 8'h00, 0);
    op("push30", 1, 8'h30, 0, 0, 8'h00, 0);
    op("push40", 1, 8'h40, 0, 0, 8'h00, 0);
    op("push50_drop", 1, 8'h50, 0, 0, 8'h00, 0);
    op("pushpop_full", 1, 8'h60, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) op("pop", 0, 8'h00, 1, 0, 8'h00, 0);
    op("pop_empty", 0, 8'h00, 1, 0, 8'h00, 0);
`else
    op("wr01", 1, 8'h01, 0, 0, 8'h00, 0);
    op("wr02_ovr", 1, 8'h02, 0, 0, 8'h00, 0);
    do_reset("ovr_clear");
    op("wr77", 1, 8'h77, 0, 0, 8'h00, 0);
    op("wr88_ack", 1, 8'h88, 1, 0, 8'h00, 0);
`endif

    op("rep_a5_rd", 0, 8'h00, 0, 1, 8'hA5, 1);
    op("rep_rd", 0, 8'h00, 0, 0, 8'h00, 1);
    op("rep_3c", 0, 8'h00, 0, 1, 8'h3C, 0);
    op("rep_4d_ovw", 0, 8'h00, 0, 1, 8'h4D, 0);
    op("rep_rd2", 0, 8'h00, 0, 0, 8'h00, 1);

    for (int i = 0; i < 40; i++) begin
      op("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // strobe held high across reset release must not fire
    @(negedge clk_sys);
    reset = 1'b1; main_cmd_wr = 1'b1; main_cmd_din = 8'h33;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    model_reset();
    push_exp();
    check_outputs("held_rst");
    main_cmd_wr = 1'b0;
    op("after_held", 1, 8'h33, 0, 0, 8'h00, 0);

    op("pre_async_cmd", 1, 8'h66, 0, 0, 8'h00, 0);
    op("pre_async_rep", 0, 8'h00, 0, 1, 8'h99, 0);
    @(negedge clk_sys);
    #1 reset = 1'b1;
    #1;
    model_reset();
    push_exp();
    check_outputs("async_rst");
    @(negedge clk_sys);
    reset = 1'b0;
    op("post_async", 1, 8'hC3, 0, 0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
